hazard_ctrl: RTL

Pipeline control block that drives the PC register's `id_shouldStall`, `id_shouldJumpOrBranch` and `nextPc` inputs, plus the IF/ID flush and ID/EX bubble controls.
- Detects load-use and branch-operand hazards against instructions in EX and MEM.
- Sequences multi-cycle stalls with a small FSM and resolves branches/jumps in ID.
- Keeps stall and flush performance counters.

It sits between the ID-stage decoder/comparator and the fetch stage.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/hazard_detect.sv | 38 +++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and constants for the CPU datapath.
package cpu_pkg;

   typedef enum logic {
      IDLE,
      HOLD
   } hz_state_t;

   localparam logic [4:0]  REG_ZERO      = 5'd0;
   localparam int unsigned PC_STEP       = 4;
   localparam logic [1:0]  STALL_LOAD_BR = 2'd2;

   function automatic logic reg_match(input logic use_r, input logic [4:0] r, input logic [4:0] rd);
      return use_r && (r != REG_ZERO) && (r == rd);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: number of stall cycles the ID instruction needs.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_useRs,
   input  logic       id_useRt,
   input  logic       id_isBranchOrJump,
   input  logic [4:0] ex_rd,
   input  logic [4:0] mem_rd,
   input  logic       ex_regWrite,
   input  logic       ex_memRead,
   input  logic       mem_regWrite,
   input  logic       mem_memRead,
   output logic [1:0] need
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = reg_match(id_useRs, id_rs, ex_rd)  || reg_match(id_useRt, id_rt, ex_rd);
   assign mem_hit = reg_match(id_useRs, id_rs, mem_rd) || reg_match(id_useRt, id_rt, mem_rd);

   // Branches compare in ID, so they must also wait on ALU results in EX and loads in MEM.
   always_comb begin
      need = '0;
      if (id_isBranchOrJump) begin
         if (ex_memRead && ex_hit)
            need = STALL_LOAD_BR;
         else if ((ex_regWrite && ex_hit) || (mem_memRead && mem_regWrite && mem_hit))
            need = 2'd1;
      end else if (ex_memRead && ex_regWrite && ex_hit) begin
         need = 2'd1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall FSM, ID-stage redirect, PC select and perf counters.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_en,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_useRs,
   input  logic             id_useRt,
   input  logic             id_isBranchOrJump,
   input  logic             id_taken,
   input  logic [PC_W-1:0]  id_target,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       mem_rd,
   input  logic             ex_regWrite,
   input  logic             ex_memRead,
   input  logic             mem_regWrite,
   input  logic             mem_memRead,
   input  logic             ext_busy,
   input  logic [PC_W-1:0]  if_pc,
   output logic             id_shouldStall,
   output logic             id_shouldJumpOrBranch,
   output logic [PC_W-1:0]  nextPc,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   hz_state_t  state;
   logic [1:0] cnt;
   logic [1:0] need;
   logic       in_hold;
   logic       stall_new;
   logic       redirect;

   hazard_detect u_detect (
      .id_rs             (id_rs),
      .id_rt             (id_rt),
      .id_useRs          (id_useRs),
      .id_useRt          (id_useRt),
      .id_isBranchOrJump (id_isBranchOrJump),
      .ex_rd             (ex_rd),
      .mem_rd            (mem_rd),
      .ex_regWrite       (ex_regWrite),
      .ex_memRead        (ex_memRead),
      .mem_regWrite      (mem_regWrite),
      .mem_memRead       (mem_memRead),
      .need              (need)
   );

   assign in_hold   = (state == HOLD);
   assign stall_new = (state == IDLE) && (need != 2'd0);
   assign redirect  = !rst && (state == IDLE) && (need == 2'd0) && !ext_busy
                      && id_isBranchOrJump && id_taken;

   // EX is frozen externally while busy, so no bubble is injected then.
   assign id_shouldStall        = !rst && (ext_busy || in_hold || stall_new);
   assign idex_bubble           = !rst && !ext_busy && (in_hold || stall_new);
   assign id_shouldJumpOrBranch = redirect;
   assign ifid_flush            = redirect;

   always_comb begin
      nextPc = '0;
      if (!rst)
         nextPc = redirect ? id_target : if_pc + PC_W'(PC_STEP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         stallCycles <= '0;
         flushCount  <= '0;
      end else if (cpu_en) begin
         if (id_shouldStall)
            stallCycles <= stallCycles + CNT_W'(1);
         if (ifid_flush)
            flushCount <= flushCount + CNT_W'(1);
         if (!ext_busy) begin
            case (state)
               IDLE: begin
                  if (need != 2'd0) begin
                     cnt   <= need - 2'd1;
                     state <= (need > 2'd1) ? HOLD : IDLE;
                  end
               end
               HOLD: begin
                  cnt <= cnt - 2'd1;
                  if (cnt == 2'd1)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
